// File: rtl/booth4_mult_pipe.sv
// Pipelined radix-4 Booth signed fixed-point multiplier with round/saturate.
// Stages: input register, S Booth/accumulate stages, round/saturate output register.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand handshake; in_ready = !out_valid | out_ready
//   a, b                  signed Q(W-FRAC).FRAC operands
//   out_valid/out_ready   result handshake; the whole pipeline stalls when not taken
//   p, ovf                saturated scaled result and clamp flag
//   prod_full             exact 2W-bit product, aligned with p
module booth4_mult_pipe #(
    parameter int W            = 24,
    parameter int FRAC         = 22,
    parameter int PP_PER_STAGE = 2,
    parameter int ROUND        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     p,
    output logic             ovf,
    output logic [2*W-1:0]   prod_full
);

    localparam int NPP = W / 2;
    localparam int S   = NPP / PP_PER_STAGE;

    localparam logic [2*W:0] RND = (ROUND != 0) ?
        ({{(2*W){1'b0}}, 1'b1} << (FRAC - 1)) : '0;
    localparam logic signed [2*W:0] MAXR =
        {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] MINR =
        {{(W+2){1'b1}}, {(W-1){1'b0}}};

    // Booth partial product k: digit from {x[2k+1],x[2k],x[2k-1]}, x[-1]=0.
    function automatic logic [2*W-1:0] booth_pp(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input int           k
    );
        logic [W:0]     xe;
        logic [2:0]     t;
        logic [2*W-1:0] m;
        xe = {x, 1'b0};
        t  = xe[2*k +: 3];
        m  = {{W{y[W-1]}}, y};
        case (t)
            3'b001, 3'b010: m = m;
            3'b011:         m = m << 1;
            3'b100:         m = -(m << 1);
            3'b101, 3'b110: m = -m;
            default:        m = '0;
        endcase
        return m << (2 * k);
    endfunction

    logic             adv;
    logic             v_q   [0:S];
    logic [W-1:0]     a_q   [0:S-1];
    logic [W-1:0]     b_q   [0:S-1];
    logic [2*W-1:0]   acc_q [1:S];
    logic [2*W-1:0]   acc_in[1:S];
    logic [2*W-1:0]   acc_d [1:S];

    logic             out_valid_q;
    logic [W-1:0]     p_q, p_d;
    logic             ovf_q, ovf_d;
    logic [2*W-1:0]   prod_q;
    logic [2*W:0]     rnd_sum;
    logic signed [2*W:0] r;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign ovf       = ovf_q;
    assign prod_full = prod_q;

    // Stage s consumes digits (s-1)*PP_PER_STAGE .. s*PP_PER_STAGE-1 of its own slot.
    always_comb begin
        acc_in[1] = '0;
        for (int s = 2; s <= S; s++) begin
            acc_in[s] = acc_q[s-1];
        end
        for (int s = 1; s <= S; s++) begin
            acc_d[s] = acc_in[s];
            for (int i = 0; i < PP_PER_STAGE; i++) begin
                acc_d[s] = acc_d[s] +
                    booth_pp(a_q[s-1], b_q[s-1], (s-1)*PP_PER_STAGE + i);
            end
        end
    end

    // One extra bit keeps the rounding add from wrapping.
    always_comb begin
        rnd_sum = {acc_q[S][2*W-1], acc_q[S]} + RND;
        r       = $signed(rnd_sum) >>> FRAC;
        p_d     = r[W-1:0];
        ovf_d   = 1'b0;
        if (r > MAXR) begin
            p_d   = {1'b0, {(W-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (r < MINR) begin
            p_d   = {1'b1, {(W-1){1'b0}}};
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= S; s++) v_q[s] <= 1'b0;
            for (int s = 0; s < S; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
            end
            for (int s = 1; s <= S; s++) acc_q[s] <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            prod_q      <= '0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            a_q[0] <= a;
            b_q[0] <= b;
            for (int s = 1; s <= S; s++) begin
                v_q[s]   <= v_q[s-1];
                acc_q[s] <= acc_d[s];
            end
            for (int s = 1; s < S; s++) begin
                a_q[s] <= a_q[s-1];
                b_q[s] <= b_q[s-1];
            end
            out_valid_q <= v_q[S];
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            prod_q      <= acc_q[S];
        end
    end

endmodule
